// File: rtl/scan_shift_register.sv
// scan_shift_register: mux-D register with a serial scan path.
// Each rising edge either parallel-loads D or shifts S_in into the LSB.
// S_out taps the MSB so cells can be chained into longer scan chains.
//
// Optional feature macro: SCAN_SHIFT_HOLD_EN adds a 'hold' input.
// When hold is set, Q keeps its value. Reset still wins over hold.
//
// Parameters:
//   WIDTH       - register bits, 1..64
//   RESET_VALUE - value loaded into Q on reset
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   hold   - (SCAN_SHIFT_HOLD_EN only) freeze Q
//   D      - parallel data input
//   S_in   - serial scan input
//   select - 0: load D, 1: shift from S_in
//   Q      - registered state
//   S_out  - serial output, Q[WIDTH-1]
module scan_shift_register #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SCAN_SHIFT_HOLD_EN
  input  logic             hold,
`endif
  input  logic [WIDTH-1:0] D,
  input  logic             S_in,
  input  logic             select,
  output logic [WIDTH-1:0] Q,
  output logic             S_out
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shift_val;

  // Shifted value: S_in enters the LSB, bits move toward the MSB.
  // A single-bit cell has no upper bits to keep.
  generate
    if (WIDTH == 1) begin : g_shift_single
      assign shift_val = S_in;
    end else begin : g_shift_multi
      assign shift_val = {q_q[WIDTH-2:0], S_in};
    end
  endgenerate

  // Next-state selection; reset is applied in the register process.
  always_comb begin
    q_d = q_q;
`ifdef SCAN_SHIFT_HOLD_EN
    if (!hold) begin
      q_d = select ? shift_val : D;
    end
`else
    q_d = select ? shift_val : D;
`endif
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q     = q_q;
  assign S_out = q_q[WIDTH-1];

endmodule

// File: tb/tb_scan_shift_register.sv
// Directed testbench for scan_shift_register: single-bit cell, 4-bit cell
// (zero and non-zero reset values), a two-cell chain, and the hold option
// when SCAN_SHIFT_HOLD_EN is defined.
module tb_scan_shift_register;

  logic       clk;
  logic       rst;
  logic       sel1, sin1, d1;
  logic       sel4, sin4;
  logic [3:0] d4;
  logic       selc, sinc;
  logic       dc0, dc1;
`ifdef SCAN_SHIFT_HOLD_EN
  logic       hold;
`endif

  logic       q1, so1;
  logic [3:0] q4, q4r;
  logic       so4, so4r;
  logic       qc0, qc1, soc0, soc1;

  int n_tests = 0;
  int n_fail  = 0;

  scan_shift_register #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst),
`ifdef SCAN_SHIFT_HOLD_EN
    .hold(1'b0),
`endif
    .D(d1), .S_in(sin1), .select(sel1), .Q(q1), .S_out(so1)
  );

  scan_shift_register #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst),
`ifdef SCAN_SHIFT_HOLD_EN
    .hold(hold),
`endif
    .D(d4), .S_in(sin4), .select(sel4), .Q(q4), .S_out(so4)
  );

  scan_shift_register #(.WIDTH(4), .RESET_VALUE(4'b0110)) u4r (
    .clk(clk), .rst(rst),
`ifdef SCAN_SHIFT_HOLD_EN
    .hold(hold),
`endif
    .D(d4), .S_in(sin4), .select(sel4), .Q(q4r), .S_out(so4r)
  );

  scan_shift_register #(.WIDTH(1)) c0 (
    .clk(clk), .rst(rst),
`ifdef SCAN_SHIFT_HOLD_EN
    .hold(1'b0),
`endif
    .D(dc0), .S_in(sinc), .select(selc), .Q(qc0), .S_out(soc0)
  );

  scan_shift_register #(.WIDTH(1)) c1 (
    .clk(clk), .rst(rst),
`ifdef SCAN_SHIFT_HOLD_EN
    .hold(1'b0),
`endif
    .D(dc1), .S_in(soc0), .select(selc), .Q(qc1), .S_out(soc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    sel1 = 1'b0; sin1 = 1'b0; d1 = 1'b0;
    sel4 = 1'b0; sin4 = 1'b0; d4 = 4'h0;
    selc = 1'b0; sinc = 1'b0; dc0 = 1'b0; dc1 = 1'b0;
`ifdef SCAN_SHIFT_HOLD_EN
    hold = 1'b0;
`endif
    #2;

    // Reset
    tick();
    check("rst_q1",    64'(q1),   64'(1'b0));
    check("rst_so1",   64'(so1),  64'(1'b0));
    check("rst_q4",    64'(q4),   64'(4'b0000));
    check("rst_q4r",   64'(q4r),  64'(4'b0110));
    check("rst_so4r",  64'(so4r), 64'(1'b0));
    check("rst_qc1",   64'(qc1),  64'(1'b0));
    rst = 1'b0;

    // Single-bit cell
    d1 = 1'b1; sel1 = 1'b0;
    tick();
    check("w1_load_q",  64'(q1),  64'(1'b1));
    check("w1_load_so", 64'(so1), 64'(1'b1));
    sel1 = 1'b1; sin1 = 1'b0;
    tick();
    check("w1_shift0", 64'(q1), 64'(1'b0));
    sin1 = 1'b1;
    tick();
    check("w1_shift1", 64'(q1), 64'(1'b1));
    sel1 = 1'b0; d1 = 1'b0; sin1 = 1'b1;
    tick();
    check("w1_d_wins", 64'(q1), 64'(1'b0));

    // 4-bit cell: load then shift 1,1,0,0
    d4 = 4'b1010; sel4 = 1'b0;
    tick();
    check("w4_load", 64'(q4), 64'(4'b1010));
    sel4 = 1'b1; sin4 = 1'b1;
    tick();
    check("w4_sh1_q",  64'(q4),  64'(4'b0101));
    check("w4_sh1_so", 64'(so4), 64'(1'b0));
    sin4 = 1'b1;
    tick();
    check("w4_sh2_q",  64'(q4),  64'(4'b1011));
    check("w4_sh2_so", 64'(so4), 64'(1'b1));
    sin4 = 1'b0;
    tick();
    check("w4_sh3_q",  64'(q4),  64'(4'b0110));
    check("w4_sh3_so", 64'(so4), 64'(1'b0));
    sin4 = 1'b0;
    tick();
    check("w4_sh4_q",  64'(q4),  64'(4'b1100));
    check("w4_sh4_so", 64'(so4), 64'(1'b1));

    // Mode switch back and forth, no settling cycle
    sel4 = 1'b0; d4 = 4'b0011;
    tick();
    check("w4_reload", 64'(q4), 64'(4'b0011));
    sel4 = 1'b1; sin4 = 1'b1;
    tick();
    check("w4_reshift", 64'(q4), 64'(4'b0111));

    // Reset beats shift
    sel4 = 1'b0; d4 = 4'b1111;
    tick();
    check("w4_load_ff", 64'(q4), 64'(4'b1111));
    sel4 = 1'b1; sin4 = 1'b0;
    tick();
    check("w4_shift_e", 64'(q4), 64'(4'b1110));
    rst = 1'b1;
    tick();
    check("w4_rst_mid",  64'(q4),   64'(4'b0000));
    check("w4r_rst_mid", 64'(q4r),  64'(4'b0110));
    check("w4_rst_so",   64'(so4),  64'(1'b0));
    rst = 1'b0;

    // Two chained single-bit cells
    selc = 1'b1; sinc = 1'b1;
    tick();
    check("chain_e1_c0", 64'(qc0), 64'(1'b1));
    check("chain_e1_c1", 64'(qc1), 64'(1'b0));
    sinc = 1'b0;
    tick();
    check("chain_e2_c1", 64'(qc1), 64'(1'b1));
    tick();
    check("chain_e3_c1", 64'(qc1), 64'(1'b0));

`ifdef SCAN_SHIFT_HOLD_EN
    // Hold keeps Q regardless of select/D/S_in
    sel4 = 1'b0; d4 = 4'b1001;
    tick();
    check("hold_pre", 64'(q4), 64'(4'b1001));
    hold = 1'b1; d4 = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_load", 64'(q4), 64'(4'b1001));
    end
    sel4 = 1'b1; sin4 = 1'b0;
    tick();
    check("hold_shift", 64'(q4), 64'(4'b1001));
    hold = 1'b0; sel4 = 1'b0;
    tick();
    check("hold_release", 64'(q4), 64'(4'b0110));
    hold = 1'b1; rst = 1'b1;
    tick();
    check("hold_rst",  64'(q4),  64'(4'b0000));
    check("hold_rstr", 64'(q4r), 64'(4'b0110));
    rst = 1'b0; hold = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
